// File: rtl/data_path_seq_pkg.sv
// Shared types, constants and the LFSR step function for the data_path_seq
// PRBS sequencer/checker.
package data_path_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int LFSR_W = 16;

    // Feedback taps of x^16+x^14+x^13+x^11+1 in shift-right form: b0, b2, b3, b5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    // first_err_idx value for a run whose bits all matched
    localparam logic [15:0] FIRST_ERR_NONE = 16'hFFFF;

    // One Fibonacci step: shift right, XOR of the taps enters at b15
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        lfsr_next = {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/data_path_seq_prbs16.sv
// 16-bit PRBS generator: load to the seed, advance one step on request,
// bit0 of the current state is the output bit.
module prbs16
    import data_path_seq_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic load_i,
    input  logic adv_i,
    output logic bit_o
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Next LFSR state: load has priority over advance
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (adv_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/data_path_seq.sv
// PRBS burst sequencer and checker for a DATA_DEPTH-stage registered 1-bit
// datapath. Drives dp_in for RUN_LEN cycles, predicts dp_out with a reference
// delay line of DATA_DEPTH+1 stages and counts mismatches (saturating).
// Optional: define FIRST_ERR_CAPTURE_EN to add first_err_idx, the run index
// of the first mismatching bit (16'hFFFF when none).
module data_path_seq
    import data_path_seq_pkg::*;
#(
    parameter int          DATA_DEPTH = 10,
    parameter int          RUN_LEN    = 256,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             dp_in,
    input  logic             dp_out
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic [15:0]      first_err_idx
`endif
);

    localparam int             CNT_W      = $clog2(RUN_LEN + DATA_DEPTH + 2);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DATA_DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                pass_q, pass_d;
    logic                dp_in_q, dp_in_d;
    logic [DATA_DEPTH:0] ref_bit_q, ref_bit_d;
    logic [DATA_DEPTH:0] ref_vld_q, ref_vld_d;
    logic                lfsr_load, lfsr_adv, prbs_bit;
    logic                cmp_en, mismatch;

    prbs16 #(
        .SEED (SEED)
    ) u_prbs (
        .clk    (clk),
        .rst_ni (rst),
        .load_i (lfsr_load),
        .adv_i  (lfsr_adv),
        .bit_o  (prbs_bit)
    );

    // dp_out is only judged in RUN/DRAIN, and only for a bit that was really driven
    assign cmp_en   = ((state_q == RUN) || (state_q == DRAIN)) && ref_vld_q[DATA_DEPTH];
    assign mismatch = cmp_en && (dp_out != ref_bit_q[DATA_DEPTH]);

    // Next-state, drive, reference-line shift and error counting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pass_d    = pass_q;
        dp_in_d   = dp_in_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        ref_bit_d = ref_bit_q;
        ref_vld_d = ref_vld_q;

        // The reference line moves every cycle outside IDLE; stage0 is empty by default
        if (state_q != IDLE) begin
            ref_bit_d[0] = 1'b0;
            ref_vld_d[0] = 1'b0;
            for (int i = 1; i <= DATA_DEPTH; i++) begin
                ref_bit_d[i] = ref_bit_q[i-1];
                ref_vld_d[i] = ref_vld_q[i-1];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                lfsr_load = 1'b1;
                err_d     = '0;
                cnt_d     = '0;
                pass_d    = 1'b0;
                dp_in_d   = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                dp_in_d      = prbs_bit;
                lfsr_adv     = 1'b1;
                ref_bit_d[0] = prbs_bit;
                ref_vld_d[0] = 1'b1;
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                dp_in_d = 1'b0;
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // Control, counter, drive and reference-line registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            dp_in_q   <= 1'b0;
            ref_bit_q <= '0;
            ref_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            dp_in_q   <= dp_in_d;
            ref_bit_q <= ref_bit_d;
            ref_vld_q <= ref_vld_d;
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    // Compares arrive in run order, so counting them gives the bit index
    logic [15:0] cmp_idx_q, cmp_idx_d;
    logic [15:0] first_q, first_d;
    logic        found_q, found_d;

    // First-mismatch capture, written at most once per run
    always_comb begin
        cmp_idx_d = cmp_idx_q;
        first_d   = first_q;
        found_d   = found_q;
        if (state_q == LOAD) begin
            cmp_idx_d = '0;
            first_d   = FIRST_ERR_NONE;
            found_d   = 1'b0;
        end else if (cmp_en) begin
            cmp_idx_d = cmp_idx_q + 16'd1;
            if (mismatch && !found_q) begin
                first_d = cmp_idx_q;
                found_d = 1'b1;
            end
        end
    end

    // First-mismatch registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_idx_q <= '0;
            first_q   <= FIRST_ERR_NONE;
            found_q   <= 1'b0;
        end else begin
            cmp_idx_q <= cmp_idx_d;
            first_q   <= first_d;
            found_q   <= found_d;
        end
    end

    assign first_err_idx = first_q;
`endif

    assign busy    = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    // The verdict is already final in DONE because the last compare lands in DRAIN
    assign pass    = done ? (err_q == '0) : pass_q;
    assign err_cnt = err_q;
    assign dp_in   = dp_in_q;

endmodule

// File: tb/tb_data_path_seq.sv
// Bench for data_path_seq: a behavioural datapath of selectable latency with
// fault injection, a PRBS/mismatch reference model, table-driven runs plus
// randomized runs, mid-run reset and a 4-bit saturating counter instance.
module tb_data_path_seq;

    localparam int D        = 10;
    localparam int RL       = 256;
    localparam int EXP_BUSY = 1 + RL + D + 1;

    logic        clk;
    logic        rst;
    logic        start, start4;
    logic        busy, done, pass, dp_in, dp_out;
    logic [15:0] err_cnt;
    logic        busy4, done4, pass4, dp_in4, dp_out4;
    logic [3:0]  err_cnt4;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [15:0] first_err_idx, first_err_idx4;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural datapath: modes 0 loopback, 1 tied 0, 2 tied 1, 3 loopback with one flipped bit
    int         dp_mode = 0;
    int         dp_lat  = D;
    int         inv_idx = 0;
    logic [11:0] sr = '0;
    int         bc = 0;
    logic       flip;

    bit prbs [RL];

    data_path_seq #(.DATA_DEPTH(D), .RUN_LEN(RL), .SEED(16'hACE1), .ERR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .dp_in(dp_in), .dp_out(dp_out)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_idx(first_err_idx)
`endif
    );

    data_path_seq #(.DATA_DEPTH(D), .RUN_LEN(RL), .SEED(16'hACE1), .ERR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err_cnt4), .dp_in(dp_in4), .dp_out(dp_out4)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_idx(first_err_idx4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        sr <= {sr[10:0], dp_in};
        bc <= busy ? bc + 1 : 0;
    end

    // Bit k reaches the comparison point in busy cycle 2+D+k
    assign flip    = (dp_mode == 3) && busy && (bc == 2 + D + inv_idx);
    assign dp_out  = (dp_mode == 1) ? 1'b0 : (dp_mode == 2) ? 1'b1 : (sr[dp_lat-1] ^ flip);
    assign dp_out4 = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit din(input int j);
        return (j >= 0 && j < RL) ? prbs[j] : 1'b0;
    endfunction

    // Reference: the bit received for run bit k is what dp_in carried lat cycles before its compare slot
    function automatic void model(input int mode, input int lat, input int idx,
                                  output int errs, output int first);
        bit r;
        errs  = 0;
        first = 'hFFFF;
        for (int k = 0; k < RL; k++) begin
            case (mode)
                1:       r = 1'b0;
                2:       r = 1'b1;
                default: r = din(k + D - lat) ^ ((mode == 3) && (k == idx));
            endcase
            if (r != prbs[k]) begin
                if (errs == 0) first = k;
                errs++;
            end
        end
    endfunction

    task automatic run_vec(input int mode, input int lat, input int idx,
                           input int exp_err, input int exp_first, input string nm);
        int busy_n, done_n;
        logic [31:0] err_at, pass_at;
        dp_mode = mode; dp_lat = lat; inv_idx = idx;
        busy_n = 0; done_n = 0; err_at = 'hDEAD; pass_at = 'hDEAD;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 320; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                err_at  = 32'(err_cnt);
                pass_at = 32'(pass);
            end
            @(negedge clk);
        end
        chk({nm, " busy_len"}, busy_n, EXP_BUSY);
        chk({nm, " done_pulses"}, done_n, 1);
        chk({nm, " err_at_done"}, err_at, exp_err);
        chk({nm, " pass_at_done"}, pass_at, (exp_err == 0) ? 1 : 0);
        chk({nm, " pass_held"}, 32'(pass), (exp_err == 0) ? 1 : 0);
`ifdef FIRST_ERR_CAPTURE_EN
        chk({nm, " first_err_idx"}, 32'(first_err_idx), exp_first);
`endif
    endtask

    typedef struct {
        int mode;
        int lat;
        int idx;
        int exp_err;
        int exp_first;
    } vec_t;

    initial begin
        vec_t vecs [9];
        logic [15:0] s;
        int busy_n, done_n, e, f;

        vecs[0] = '{0, 10, 0,   0, 0};
        vecs[1] = '{1, 10, 0,   0, 0};
        vecs[2] = '{0, 11, 0,   0, 0};
        vecs[3] = '{0, 9,  0,   0, 0};
        vecs[4] = '{3, 10, 37,  0, 0};
        for (int v = 5; v < 9; v++) begin
            vecs[v].mode = int'($urandom_range(0, 3));
            vecs[v].lat  = int'($urandom_range(9, 11));
            vecs[v].idx  = int'($urandom_range(0, RL - 1));
        end

        s = 16'hACE1;
        for (int k = 0; k < RL; k++) begin
            prbs[k] = s[0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
        for (int v = 0; v < 9; v++) begin
            model(vecs[v].mode, vecs[v].lat, vecs[v].idx, vecs[v].exp_err, vecs[v].exp_first);
        end

        start = 1'b0; start4 = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pass", 32'(pass), 0);
        chk("rst err_cnt", 32'(err_cnt), 0);
        chk("rst dp_in", 32'(dp_in), 0);
        chk("rst err_cnt4", 32'(err_cnt4), 0);
`ifdef FIRST_ERR_CAPTURE_EN
        chk("rst first_err_idx", 32'(first_err_idx), 32'hFFFF);
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v].mode, vecs[v].lat, vecs[v].idx, vecs[v].exp_err, vecs[v].exp_first,
                    $sformatf("vec%0d(m%0d,l%0d,i%0d)", v, vecs[v].mode, vecs[v].lat, vecs[v].idx));
        end

        // Reset in RUN cycle 100 of a failing run: everything back to reset values, no done
        dp_mode = 1; dp_lat = D;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 200 && bc != 101; i++) @(negedge clk);
        chk("midrst reached_run100", 32'(bc), 101);
        chk("midrst err_nonzero_before", 32'(err_cnt != 0), 1);
        rst = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst pass", 32'(pass), 0);
        chk("midrst err_cnt", 32'(err_cnt), 0);
        chk("midrst dp_in", 32'(dp_in), 0);
        @(negedge clk); rst = 1'b1;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            @(negedge clk);
        end
        chk("midrst no_busy_after", busy_n, 0);
        chk("midrst no_done_after", done_n, 0);
        run_vec(0, D, 0, 0, 'hFFFF, "after_rst clean");

        // 4-bit counter, dp_out tied 1, start re-pulsed while running
        model(2, D, 0, e, f);
        if (e > 15) e = 15;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 50 || i == 200) start4 = 1'b1;
            if (i == 51 || i == 201) start4 = 1'b0;
            if (busy4) busy_n++;
            if (done4) done_n++;
            @(negedge clk);
        end
        chk("sat4 busy_len", busy_n, EXP_BUSY);
        chk("sat4 done_pulses", done_n, 1);
        chk("sat4 err_cnt", 32'(err_cnt4), e);
        chk("sat4 pass", 32'(pass4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_path_seq.md
Name: data_path_seq

Overview:
- PRBS sequencer/checker that drives the 1-bit input of a registered datapath chain and checks its output.
- The chain is DATA_DEPTH register stages, each fed by a comb path.
- Runs a fixed-length PRBS burst on start, predicts the chain output with an internal reference delay line, and counts mismatches.
- Sits beside the datapath instance as its stimulus/self-check controller in timing-closure test designs.

Parameters:
- DATA_DEPTH, 10, register stages in the controlled datapath (latency in cycles).
- RUN_LEN, 256, PRBS bits driven per run (>=1).
- SEED, 16'hACE1, LFSR load value; zero replaced by 16'h0001.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  run request, sampled in IDLE only.
- busy  out  1  high in LOAD/RUN/DRAIN.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  result of last run, valid from DONE until next start.
- err_cnt  out  ERR_W  mismatches in last/current run.
- dp_in  out  1  registered drive to datapath input.
- dp_out  in  1  datapath output.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, pass=0, err_cnt=0, dp_in=0; delay line and valid flags cleared.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD, 1 cycle: LFSR<=SEED, err_cnt<=0, bit counter<=0, pass<=0 -> RUN.
  - RUN, RUN_LEN cycles: dp_in<=LFSR bit0; LFSR advances; stage0 of the reference line <= same bit with valid=1; after RUN_LEN bits -> DRAIN.
  - DRAIN, DATA_DEPTH+1 cycles: dp_in<=0, stage0 valid=0 -> DONE.
  - DONE, 1 cycle: done=1; pass<=(err_cnt==0) -> IDLE.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift right; feedback = b0^b2^b3^b5 into b15.
- Reference line: DATA_DEPTH+1 stages of {valid, bit}, shifting every cycle in every state except IDLE.
  - A bit driven on dp_in in cycle t is compared with dp_out in cycle t+DATA_DEPTH, i.e. when it reaches the last stage.
  - Compare only when the last-stage valid=1; a mismatch increments err_cnt.
- err_cnt saturates at 2^ERR_W-1; no wrap.
- Run length: busy high exactly 1+RUN_LEN+DATA_DEPTH+1 cycles per run.
- start while busy or in DONE: ignored (no queueing).
- rst asserted mid-run: immediate return to IDLE with reset values; no done pulse.
- dp_out is not sampled in IDLE, LOAD or DONE.

Optional Feature:
- Macro: FIRST_ERR_CAPTURE_EN.
- Defined: adds output first_err_idx [15:0]. It holds the 0-based run index of the first mismatching bit and is 16'hFFFF if there was none. It is cleared to 16'hFFFF in LOAD and on reset, and is written once per run. Requires a 16-bit index travelling with each reference stage (or a compare counter).
- Undefined: port and logic absent; other behaviour identical.

Decomposition:
- Package data_path_seq_pkg:
  - state enum: IDLE, LOAD, RUN, DRAIN, DONE;
  - LFSR_W=16, tap constants, lfsr_next function;
  - FIRST_ERR_NONE=16'hFFFF.
- Sub-module prbs16: load/advance ports, bit0 output.
- FSM, counters and reference line stay in data_path_seq.

Test Plan:
1. Loopback through a real 10-stage datapath, start pulse -> busy exactly 268 cycles, done pulse, pass=1, err_cnt=0.
2. dp_out tied 0 -> err_cnt = number of ones among the first 256 PRBS bits from 16'hACE1 (model-computed), pass=0.
3. Datapath modelled with 11 stages (off-by-one latency) -> err_cnt>0, pass=0; 9 stages likewise.
4. Single dp_out inversion at run bit index 37 -> err_cnt=1, pass=0; with FIRST_ERR_CAPTURE_EN, first_err_idx=37.
5. rst low at RUN cycle 100 -> outputs at reset values immediately, no done; new start after release -> clean pass, err_cnt=0.
6. ERR_W=4, dp_out tied 1, plus start re-pulsed during RUN -> single run only, err_cnt saturates at 15.
